// File: rtl/abp_packet_rx.sv
// ABP packet receiver: extracts the alternating bit and counter value from fixed-length Ethernet frames.
// Optional EtherType filtering is enabled by defining ABP_RX_ETHERTYPE_CHECK_EN.
module abp_packet_rx #(
   parameter int          DATA_WIDTH  = 8,
   parameter int          VALUE_SIZE  = 4,
   parameter int          PACKET_SIZE = 64,
   parameter logic [15:0] ETHERTYPE   = 16'h88B5
) (
   input  logic                    aclk,
   input  logic                    reset,
   input  logic                    s_eth_rx_tvalid,
   input  logic [DATA_WIDTH-1:0]   s_eth_rx_tdata,
   input  logic                    s_eth_rx_tlast,
   output logic                    s_eth_rx_tready,
   output logic                    m_abp_valid,
   output logic [VALUE_SIZE*8-1:0] m_abp_value,
   output logic                    m_abp_bit,
   input  logic                    m_abp_ready,
   output logic                    busy,
   output logic                    error_early_termination,
   output logic                    error_long_frame
);

   localparam int CW = $clog2(PACKET_SIZE + 1);
   localparam int VW = VALUE_SIZE * 8;

   localparam logic [1:0] RECV = 2'd0;
   localparam logic [1:0] DROP = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   localparam logic [CW-1:0] LAST_IDX   = CW'(PACKET_SIZE - 1);
   localparam logic [CW-1:0] ETH_HI_IDX = CW'(12);
   localparam logic [CW-1:0] ETH_LO_IDX = CW'(13);
   localparam logic [CW-1:0] BIT_IDX    = CW'(14);
   localparam logic [CW-1:0] VAL_FIRST  = CW'(15);
   localparam logic [CW-1:0] VAL_LAST   = CW'(14 + VALUE_SIZE);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          tready_q, tready_d;
   logic          valid_q, valid_d;
   logic [VW-1:0] value_q, value_d;
   logic          bit_q, bit_d;
   logic [VW-1:0] shift_q, shift_d;
   logic          bit_sh_q, bit_sh_d;
   logic          early_q, early_d;
   logic          long_q, long_d;
   logic          xfer;
   logic          frame_ok;

   assign xfer = s_eth_rx_tvalid && tready_q;

`ifdef ABP_RX_ETHERTYPE_CHECK_EN
   logic [15:0] etype_q, etype_d;

   always_comb begin
      etype_d = etype_q;
      if (xfer && state_q == RECV) begin
         if (count_q == ETH_HI_IDX)      etype_d[15:8] = s_eth_rx_tdata[7:0];
         else if (count_q == ETH_LO_IDX) etype_d[7:0]  = s_eth_rx_tdata[7:0];
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) etype_q <= '0;
      else       etype_q <= etype_d;
   end

   assign frame_ok = (etype_q == ETHERTYPE);
`else
   logic [15:0] unused_ethertype;
   assign unused_ethertype = ETHERTYPE;
   assign frame_ok         = 1'b1;
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      valid_d  = valid_q;
      value_d  = value_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      bit_sh_d = bit_sh_q;
      early_d  = 1'b0;
      long_d   = 1'b0;

      case (state_q)
         RECV: begin
            if (xfer) begin
               // Payload is staged in shadow registers and only published on a good frame end.
               if (count_q == BIT_IDX) bit_sh_d = s_eth_rx_tdata[0];
               if (count_q >= VAL_FIRST && count_q <= VAL_LAST)
                  shift_d = (shift_q << 8) | VW'(s_eth_rx_tdata);

               if (s_eth_rx_tlast) begin
                  count_d = '0;
                  if (count_q != LAST_IDX) begin
                     early_d = 1'b1;
                  end else if (frame_ok) begin
                     state_d = HOLD;
                     valid_d = 1'b1;
                     value_d = shift_d;
                     bit_d   = bit_sh_d;
                  end
               end else if (count_q == LAST_IDX) begin
                  long_d  = 1'b1;
                  state_d = DROP;
                  count_d = count_q + CW'(1);
               end else begin
                  count_d = count_q + CW'(1);
               end
            end
         end
         DROP: begin
            if (xfer && s_eth_rx_tlast) begin
               state_d = RECV;
               count_d = '0;
            end
         end
         HOLD: begin
            if (valid_q && m_abp_ready) begin
               state_d = RECV;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = RECV;
            count_d = '0;
            valid_d = 1'b0;
         end
      endcase

      tready_d = (state_d != HOLD);
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous and clears every flop, including the published value.
   always_ff @(posedge aclk) begin
      if (reset) begin
         state_q  <= RECV;
         count_q  <= '0;
         tready_q <= 1'b0;
         valid_q  <= 1'b0;
         value_q  <= '0;
         bit_q    <= 1'b0;
         shift_q  <= '0;
         bit_sh_q <= 1'b0;
         early_q  <= 1'b0;
         long_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         tready_q <= tready_d;
         valid_q  <= valid_d;
         value_q  <= value_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         bit_sh_q <= bit_sh_d;
         early_q  <= early_d;
         long_q   <= long_d;
      end
   end

   assign s_eth_rx_tready         = tready_q;
   assign m_abp_valid             = valid_q;
   assign m_abp_value             = value_q;
   assign m_abp_bit               = bit_q;
   assign busy                    = (count_q != '0) || (state_q != RECV);
   assign error_early_termination = early_q;
   assign error_long_frame        = long_q;

endmodule

// File: tb/tb_abp_packet_rx.sv
// Directed bench for abp_packet_rx: decode, backpressure, short/long frames, mid-frame reset, EtherType.
module tb_abp_packet_rx;

   logic        aclk = 1'b0;
   logic        reset = 1'b1;
   logic        s_eth_rx_tvalid = 1'b0;
   logic [7:0]  s_eth_rx_tdata = 8'h00;
   logic        s_eth_rx_tlast = 1'b0;
   logic        s_eth_rx_tready;
   logic        m_abp_valid;
   logic [31:0] m_abp_value;
   logic        m_abp_bit;
   logic        m_abp_ready = 1'b0;
   logic        busy;
   logic        error_early_termination;
   logic        error_long_frame;

   int n_checks = 0;
   int n_fail   = 0;
   int n_early  = 0;
   int n_long   = 0;
   int n_valid  = 0;

   abp_packet_rx dut (
      .aclk                    (aclk),
      .reset                   (reset),
      .s_eth_rx_tvalid         (s_eth_rx_tvalid),
      .s_eth_rx_tdata          (s_eth_rx_tdata),
      .s_eth_rx_tlast          (s_eth_rx_tlast),
      .s_eth_rx_tready         (s_eth_rx_tready),
      .m_abp_valid             (m_abp_valid),
      .m_abp_value             (m_abp_value),
      .m_abp_bit               (m_abp_bit),
      .m_abp_ready             (m_abp_ready),
      .busy                    (busy),
      .error_early_termination (error_early_termination),
      .error_long_frame        (error_long_frame)
   );

   always #5 aclk = ~aclk;

   // Cycle-level pulse tallies, sampled on the falling edge.
   always @(negedge aclk) begin
      if (!reset) begin
         if (error_early_termination) n_early++;
         if (error_long_frame)        n_long++;
         if (m_abp_valid)             n_valid++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] byte_of(input int idx, input logic b,
                                          input logic [31:0] v, input logic [15:0] et);
      logic [31:0] t;
      if (idx == 12) return et[15:8];
      if (idx == 13) return et[7:0];
      if (idx == 14) return {7'h2A, b};
      if (idx >= 15 && idx <= 18) begin
         t = v >> (8 * (18 - idx));
         return t[7:0];
      end
      return 8'(idx) ^ 8'hA5;
   endfunction

   // Presents one byte and returns #1 after the edge on which it was accepted.
   task automatic send_byte(input logic [7:0] d, input logic l);
      int guard = 0;
      s_eth_rx_tvalid = 1'b1;
      s_eth_rx_tdata  = d;
      s_eth_rx_tlast  = l;
      while (s_eth_rx_tready !== 1'b1 && guard < 200) begin
         @(posedge aclk); #1;
         guard++;
      end
      if (guard >= 200) check("tready_timeout", {31'b0, s_eth_rx_tready}, 32'd1);
      @(posedge aclk); #1;
      s_eth_rx_tvalid = 1'b0;
      s_eth_rx_tlast  = 1'b0;
   endtask

   task automatic send_frame(input int len, input logic b, input logic [31:0] v, input logic [15:0] et);
      for (int i = 0; i < len; i++) send_byte(byte_of(i, b, v, et), i == len - 1);
   endtask

   task automatic check_decode(input string tag, input logic [31:0] v, input logic b);
      check({tag, "_valid"}, {31'b0, m_abp_valid}, 32'd1);
      check({tag, "_value"}, m_abp_value, v);
      check({tag, "_bit"},   {31'b0, m_abp_bit}, {31'b0, b});
   endtask

   initial begin
      int e0, l0, v0;

      // Reset values.
      repeat (3) @(posedge aclk);
      #1;
      check("rst_tready", {31'b0, s_eth_rx_tready}, 32'd0);
      check("rst_valid",  {31'b0, m_abp_valid}, 32'd0);
      check("rst_value",  m_abp_value, 32'd0);
      check("rst_bit",    {31'b0, m_abp_bit}, 32'd0);
      check("rst_busy",   {31'b0, busy}, 32'd0);
      check("rst_errs",   {30'b0, error_early_termination, error_long_frame}, 32'd0);
      reset = 1'b0;
      @(posedge aclk); #1;
      check("post_rst_tready", {31'b0, s_eth_rx_tready}, 32'd1);

      // Good frame, sink always ready: one-cycle valid right after tlast.
      m_abp_ready = 1'b1;
      v0 = n_valid;
      send_frame(64, 1'b1, 32'h0000012C, 16'h88B5);
      check_decode("good1", 32'h0000012C, 1'b1);
      check("good1_tready_hold", {31'b0, s_eth_rx_tready}, 32'd0);
      check("good1_busy", {31'b0, busy}, 32'd1);
      @(posedge aclk); #1;
      check("good1_valid_drop", {31'b0, m_abp_valid}, 32'd0);
      check("good1_tready_back", {31'b0, s_eth_rx_tready}, 32'd1);
      check("good1_busy_idle", {31'b0, busy}, 32'd0);
      check("good1_valid_cycles", n_valid - v0, 32'd1);

      // Backpressure: hold for 5 cycles while the next frame's first byte waits.
      m_abp_ready = 1'b0;
      send_frame(64, 1'b0, 32'hDEADBEEF, 16'h88B5);
      check_decode("hold", 32'hDEADBEEF, 1'b0);
      s_eth_rx_tvalid = 1'b1;
      s_eth_rx_tdata  = byte_of(0, 1'b0, 32'h0, 16'h0);
      for (int k = 0; k < 5; k++) begin
         @(posedge aclk); #1;
         check("hold_valid",  {31'b0, m_abp_valid}, 32'd1);
         check("hold_value",  m_abp_value, 32'hDEADBEEF);
         check("hold_tready", {31'b0, s_eth_rx_tready}, 32'd0);
      end
      m_abp_ready = 1'b1;
      @(posedge aclk); #1;
      s_eth_rx_tvalid = 1'b0;
      check("hold_release_valid",  {31'b0, m_abp_valid}, 32'd0);
      check("hold_release_tready", {31'b0, s_eth_rx_tready}, 32'd1);
      check("hold_no_byte_taken",  {31'b0, busy}, 32'd0);

      // Ready with no pending data changes nothing.
      repeat (2) @(posedge aclk);
      #1;
      check("idle_ready_valid", {31'b0, m_abp_valid}, 32'd0);
      check("idle_ready_busy",  {31'b0, busy}, 32'd0);

      // Early termination at byte 20.
      e0 = n_early; v0 = n_valid;
      send_frame(21, 1'b1, 32'h11111111, 16'h88B5);
      check("early_pulse", {31'b0, error_early_termination}, 32'd1);
      check("early_no_valid", {31'b0, m_abp_valid}, 32'd0);
      @(posedge aclk); #1;
      check("early_pulse_end", {31'b0, error_early_termination}, 32'd0);
      check("early_busy", {31'b0, busy}, 32'd0);
      check("early_value_kept", m_abp_value, 32'hDEADBEEF);
      check("early_bit_kept", {31'b0, m_abp_bit}, 32'd0);
      send_frame(64, 1'b1, 32'h01020304, 16'h88B5);
      check_decode("after_early", 32'h01020304, 1'b1);
      @(posedge aclk); #1;
      check("early_pulse_count", n_early - e0, 32'd1);
      check("early_valid_count", n_valid - v0, 32'd1);

      // 70-byte frame: long-frame pulse on byte 63, tail absorbed.
      l0 = n_long; v0 = n_valid;
      for (int i = 0; i < 70; i++) begin
         send_byte(byte_of(i, 1'b0, 32'h22222222, 16'h88B5), i == 69);
         if (i == 63) check("long_pulse", {31'b0, error_long_frame}, 32'd1);
         if (i == 64) check("long_pulse_end", {31'b0, error_long_frame}, 32'd0);
         if (i == 66) check("long_drop_tready", {31'b0, s_eth_rx_tready}, 32'd1);
      end
      @(posedge aclk); #1;
      check("long_pulse_count", n_long - l0, 32'd1);
      check("long_no_valid", n_valid - v0, 32'd0);
      check("long_value_kept", m_abp_value, 32'h01020304);
      check("long_busy", {31'b0, busy}, 32'd0);
      send_frame(64, 1'b0, 32'hCAFEF00D, 16'h88B5);
      check_decode("after_long", 32'hCAFEF00D, 1'b0);
      @(posedge aclk); #1;

      // Reset in the middle of a frame at byte 30.
      e0 = n_early; l0 = n_long;
      for (int i = 0; i < 30; i++) send_byte(byte_of(i, 1'b1, 32'h33333333, 16'h88B5), 1'b0);
      s_eth_rx_tvalid = 1'b1;
      s_eth_rx_tdata  = byte_of(30, 1'b1, 32'h33333333, 16'h88B5);
      reset = 1'b1;
      @(posedge aclk); #1;
      s_eth_rx_tvalid = 1'b0;
      check("midrst_tready", {31'b0, s_eth_rx_tready}, 32'd0);
      check("midrst_valid",  {31'b0, m_abp_valid}, 32'd0);
      check("midrst_value",  m_abp_value, 32'd0);
      check("midrst_bit",    {31'b0, m_abp_bit}, 32'd0);
      check("midrst_busy",   {31'b0, busy}, 32'd0);
      reset = 1'b0;
      @(posedge aclk); #1;
      check("midrst_tready_back", {31'b0, s_eth_rx_tready}, 32'd1);
      send_frame(64, 1'b1, 32'h0000ABCD, 16'h88B5);
      check_decode("after_rst", 32'h0000ABCD, 1'b1);
      @(posedge aclk); #1;
      check("midrst_no_errs", (n_early - e0) + (n_long - l0), 32'd0);

      // Foreign EtherType.
      e0 = n_early; l0 = n_long; v0 = n_valid;
      send_frame(64, 1'b0, 32'h44556677, 16'h0800);
`ifdef ABP_RX_ETHERTYPE_CHECK_EN
      check("etype_drop_valid", {31'b0, m_abp_valid}, 32'd0);
      check("etype_drop_value", m_abp_value, 32'h0000ABCD);
      @(posedge aclk); #1;
      check("etype_drop_counts", (n_early - e0) + (n_long - l0) + (n_valid - v0), 32'd0);
      send_frame(64, 1'b0, 32'h44556677, 16'h88B5);
      check_decode("etype_match", 32'h44556677, 1'b0);
`else
      check_decode("etype_ignored", 32'h44556677, 1'b0);
      @(posedge aclk); #1;
      check("etype_ignored_errs", (n_early - e0) + (n_long - l0), 32'd0);
`endif
      @(posedge aclk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
